// File: rtl/vc_test_checking_sink.sv
// Val/rdy test sink: checks each received message against a preloaded expected table,
// optionally inserting LFSR-driven backpressure, and reports error status when the run ends.
//
// state | meaning
// IDLE  | after reset; expected table writable, waiting for cfg_start
// RUN   | receiving and checking messages
// DONE  | programmed count received; in_val here flags overflow
module vc_test_checking_sink #(
    parameter int          p_msg_sz    = 8,
    parameter int          p_num_msgs  = 16,
    parameter int          p_max_stall = 0,
    parameter logic [15:0] p_lfsr_seed = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_we,
    input  logic [$clog2(p_num_msgs)-1:0] cfg_addr,
    input  logic [p_msg_sz-1:0]           cfg_msg,
    input  logic [$clog2(p_num_msgs):0]   cfg_count,
    input  logic                          cfg_start,
    input  logic                          in_val,
    output logic                          in_rdy,
    input  logic [p_msg_sz-1:0]           in_msg,
    output logic                          done,
    output logic [15:0]                   num_errors,
    output logic                          err_pulse,
    output logic [$clog2(p_num_msgs)-1:0] err_idx,
    output logic [p_msg_sz-1:0]           err_got,
    output logic                          overflow
);
    localparam int AW = $clog2(p_num_msgs);
    localparam int CW = AW + 1;
    localparam int SW = (p_max_stall > 0) ? $clog2(p_max_stall + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [p_msg_sz-1:0] r_table [p_num_msgs];
    logic [CW-1:0]       r_count;
    logic [AW-1:0]       r_index;
    logic [SW-1:0]       r_stall;
    logic [15:0]         r_lfsr;
    logic [15:0]         r_num_errors;
    logic                r_err_pulse;
    logic [AW-1:0]       r_err_idx;
    logic [p_msg_sz-1:0] r_err_got;
    logic                r_overflow;

    logic [CW-1:0]       w_count_clamped;
    logic                w_start;
    logic                w_xfer;
    logic                w_last;
    logic                w_mismatch;
    logic [15:0]         w_lfsr_nxt;
    logic [SW-1:0]       w_stall_load;

    assign w_count_clamped = (cfg_count > CW'(p_num_msgs)) ? CW'(p_num_msgs) : cfg_count;
    assign w_start         = cfg_start && (r_state != S_RUN);
    assign w_xfer          = in_val && in_rdy;
    assign w_last          = ({1'b0, r_index} == (r_count - CW'(1)));
    assign w_mismatch      = (in_msg != r_table[r_index]);
    // Galois form of x^16+x^14+x^13+x^11+1
    assign w_lfsr_nxt      = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
    assign w_stall_load    = SW'(w_lfsr_nxt % 16'(p_max_stall + 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (cfg_start) w_state_nxt = (w_count_clamped == '0) ? S_DONE : S_RUN;
            S_RUN:          if (w_xfer && w_last) w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_rdy = (r_state == S_RUN) && (r_stall == '0);
        done   = (r_state == S_DONE);
    end

    // Table is write-only from the config side and deliberately not reset;
    // a write in the start cycle lands before RUN's first compare.
    always_ff @(posedge clk) begin
        if (cfg_we && r_state == S_IDLE) r_table[cfg_addr] <= cfg_msg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count      <= '0;
            r_index      <= '0;
            r_stall      <= '0;
            r_lfsr       <= p_lfsr_seed;
            r_num_errors <= '0;
            r_err_pulse  <= 1'b0;
            r_err_idx    <= '0;
            r_err_got    <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;
            if (w_start) begin
                r_count      <= w_count_clamped;
                r_index      <= '0;
                r_stall      <= '0;
                r_lfsr       <= p_lfsr_seed;
                r_num_errors <= '0;
                r_overflow   <= 1'b0;
            end else if (r_state == S_RUN) begin
                if (r_stall != '0) r_stall <= r_stall - SW'(1);
                if (w_xfer) begin
                    r_lfsr  <= w_lfsr_nxt;
                    r_index <= r_index + AW'(1);
                    if (!w_last) r_stall <= w_stall_load;
                    if (w_mismatch) begin
                        r_err_pulse <= 1'b1;
                        r_err_idx   <= r_index;
                        r_err_got   <= in_msg;
                        if (r_num_errors != 16'hFFFF) r_num_errors <= r_num_errors + 16'd1;
                    end
                end
            end else if (r_state == S_DONE && in_val) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign num_errors = r_num_errors;
    assign err_pulse  = r_err_pulse;
    assign err_idx    = r_err_idx;
    assign err_got    = r_err_got;
    assign overflow   = r_overflow;

endmodule
